// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: op codes, datapath width and arbiter limits.
package alu_arbiter_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int ALU_ARB_MAX_REQ = 8;

    // Codes 10..15 are unused; the ALU answers them with 0.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op;

endpackage

// File: rtl/alu_rtl.sv
// Shared combinational ALU. Wrap-around arithmetic, shift amount taken from
// the low log2(W) bits of b, signed/unsigned set-less-than.
module alu_rtl
    import alu_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  alu_op          op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y
);

    localparam int SW = $clog2(W);

    logic [SW-1:0] shamt;

    assign shamt = b[SW-1:0];

    // Evaluate the selected operation; unknown codes give 0.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_SLT:  y[0] = $signed(a) < $signed(b);
            ALU_SLTU: y[0] = a < b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Produces a one-hot grant, the winner index and an any-grant flag.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters. A requester is eligible when it
// has a request and its response slot is empty or being drained this cycle.
// Handshake: a transfer happens on a channel when valid and ready are both
// high at a rising edge; req_ready is a combinational function of req_valid,
// rsp_ready and registered state, so requesters must not derive req_valid
// from req_ready. Results land in per-requester slots one cycle after grant.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = alu_arbiter_pkg::WORD_SIZE,
    parameter int NUM_REQ   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  alu_op [NUM_REQ-1:0]                req_op,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]  req_a,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]  req_b,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [NUM_REQ-1:0][WORD_SIZE-1:0]  rsp_data
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
        $error("alu_arbiter: NUM_REQ must be in 2..%0d", ALU_ARB_MAX_REQ);
    end

    logic [PW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        win_idx;
    logic                 win_any;
    alu_op                alu_op_sel;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [WORD_SIZE-1:0] alu_y;

    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // No grants are visible while the block is held in reset.
    assign req_ready = rst_n ? grant : '0;

    // Operand mux steered by the winner index.
    assign alu_op_sel = req_op[win_idx];
    assign alu_a      = req_a[win_idx];
    assign alu_b      = req_b[win_idx];

    alu_rtl #(
        .W (WORD_SIZE)
    ) u_alu (
        .op (alu_op_sel),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Advance the round-robin pointer past the winner on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (win_any) begin
            rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    // Response slots: a grant overwrites (even while draining), a drain alone
    // empties, otherwise the slot holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_data[i]  <= alu_y;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;
    localparam int N = 2;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    alu_op [N-1:0]       req_op;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [N-1:0][W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .WORD_SIZE (W),
        .NUM_REQ   (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = {ALU_ADD, ALU_ADD};
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Inputs change on the falling edge; registered outputs are sampled 1ns
    // after the rising edge, combinational ready 1ns after the falling edge.
    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input alu_op op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        req_op[p] = op;
        req_a[p]  = a;
        req_b[p]  = b;
        req_valid[p] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #2;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 2'b11;
        drive(0, ALU_ADD, 32'd5, 32'd7);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        after_rise();
        checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rsp_valid[0]); end
        checks++; if (rsp_data[0] !== 32'd12) begin errors++; $display("FAIL single_data: got %0d expected 12", rsp_data[0]); end
        checks++; if (dut.rr_ptr !== 1'b1) begin errors++; $display("FAIL single_ptr: got %0d expected 1", dut.rr_ptr); end
        @(negedge clk);
        req_valid = '0;
        after_rise();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_drain: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g;
        do_reset();
        rsp_ready = 2'b11;
        drive(0, ALU_ADD, 32'd1, 32'd2);
        drive(1, ALU_SUB, 32'd10, 32'd3);
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", k, req_ready, exp_g); end
            after_rise();
            if (k == 0) begin
                checks++; if (rsp_data[0] !== 32'd3) begin errors++; $display("FAIL contention_data0: got %0d expected 3", rsp_data[0]); end
            end
            if (k == 1) begin
                checks++; if (rsp_data[1] !== 32'd7) begin errors++; $display("FAIL contention_data1: got %0d expected 7", rsp_data[1]); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 2'b11;
        drive(0, ALU_ADD, 32'd2, 32'd3);
        after_rise();
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        drive(0, ALU_SLL, 32'd1, 32'd4);
        drive(1, ALU_ADD, 32'd100, 32'd1);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_ready_a: got %b expected 10", req_ready); end
        after_rise();
        checks++; if (rsp_data[0] !== 32'd5) begin errors++; $display("FAIL bp_hold_a: got %0d expected 5", rsp_data[0]); end
        checks++; if (rsp_data[1] !== 32'd101) begin errors++; $display("FAIL bp_port1: got %0d expected 101", rsp_data[1]); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_ready_b: got %b expected 10", req_ready); end
        after_rise();
        checks++; if (rsp_data[0] !== 32'd5 || rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_b: got %0d/%b expected 5/1", rsp_data[0], rsp_valid[0]); end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        req_valid[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready: got %b expected 01", req_ready); end
        after_rise();
        checks++; if (rsp_data[0] !== 32'd16 || rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_release_data: got %0d/%b expected 16/1", rsp_data[0], rsp_valid[0]); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_drain_refill();
        do_reset();
        rsp_ready = 2'b11;
        drive(0, ALU_XOR, 32'h0000_00F0, 32'h0000_000F);
        after_rise();
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hFF) begin errors++; $display("FAIL refill_first: got %b/%h expected 1/ff", rsp_valid[0], rsp_data[0]); end
        @(negedge clk);
        drive(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL refill_ready: got %b expected 01", req_ready); end
        after_rise();
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd1) begin errors++; $display("FAIL refill_second: got %b/%h expected 1/1", rsp_valid[0], rsp_data[0]); end
        @(negedge clk);
        req_valid = '0;
        after_rise();
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL refill_drain: got %b expected 0", rsp_valid[0]); end
        @(negedge clk);
    endtask

    task automatic test_invalid_op();
        alu_op bad;
        bad = alu_op'(4'hF);
        rsp_ready = 2'b11;
        drive(1, bad, 32'd123, 32'd456);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL invalid_ready: got %b expected 10", req_ready); end
        after_rise();
        checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== '0) begin errors++; $display("FAIL invalid_result: got %b/%h expected 1/0", rsp_valid[1], rsp_data[1]); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 2'b00;
        drive(1, ALU_ADD, 32'd20, 32'd22);
        after_rise();
        @(negedge clk);
        req_valid[1] = 1'b0;
        drive(0, ALU_ADD, 32'd8, 32'd9);
        after_rise();
        checks++; if (rsp_valid !== 2'b11 || dut.rr_ptr !== 1'b1) begin errors++; $display("FAIL mid_setup: got %b/%0d expected 11/1", rsp_valid, dut.rr_ptr); end
        @(negedge clk);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 2'b00 || rsp_data !== '0) begin errors++; $display("FAIL mid_clear: got %b/%h expected 00/0", rsp_valid, rsp_data); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready: got %b expected 00", req_ready); end
        checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL mid_ptr: got %0d expected 0", dut.rr_ptr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b expected 01", req_ready); end
        after_rise();
        checks++; if (rsp_data[0] !== 32'd17) begin errors++; $display("FAIL mid_first_data: got %0d expected 17", rsp_data[0]); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = {ALU_ADD, ALU_ADD};
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_drain_refill();
        test_invalid_op();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
